// File: rtl/key_debounce_multi_if.sv
// Key debouncer bundle: raw pins in, debounced level and event pulses out.
interface key_debounce_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic              any_event;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  any_event
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output any_event
    );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press, release and long-press events.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int JITTER_CYC  = 180000,
    parameter int LONG_CYC    = 12000000,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic               clk_12m,
    input  logic               rst_n,
    key_debounce_multi_if.slave bus
);
    localparam int CW = $clog2(LONG_CYC + 1);
    localparam logic [CW-1:0] JIT_M1   = CW'(JITTER_CYC - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DEBP = 3'd1;
    localparam logic [2:0] S_PRES = 3'd2;
    localparam logic [2:0] S_HELD = 3'd3;
    localparam logic [2:0] S_DEBR = 3'd4;

    logic [1:0] rst_q;
    logic       srst_n;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end

    assign srst_n = rst_q[1];

    // Normalise to 1 = pressed before synchronising.
    logic [N_KEYS-1:0] lvl_n;
    logic [N_KEYS-1:0] s1;
    logic [N_KEYS-1:0] s2;

    assign lvl_n = (ACTIVE_HIGH != 0) ? bus.key_in : ~bus.key_in;

    always_ff @(posedge clk_12m or negedge srst_n) begin
        if (!srst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= lvl_n;
            s2 <= s1;
        end
    end

    logic [N_KEYS-1:0] down_v;
    logic [N_KEYS-1:0] pr_v;
    logic [N_KEYS-1:0] rl_v;
    logic [N_KEYS-1:0] lg_v;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [2:0]    st;
        logic [CW-1:0] cnt;
        logic          held;
        logic          down;
        logic          pr;
        logic          rl;
        logic          lg;

        always_ff @(posedge clk_12m or negedge srst_n) begin
            if (!srst_n) begin
                st   <= S_IDLE;
                cnt  <= '0;
                held <= 1'b0;
                down <= 1'b0;
                pr   <= 1'b0;
                rl   <= 1'b0;
                lg   <= 1'b0;
            end else begin
                pr <= 1'b0;
                rl <= 1'b0;
                lg <= 1'b0;
                unique case (st)
                    S_IDLE: begin
                        if (s2[i]) begin
                            cnt <= '0;
                            st  <= S_DEBP;
                        end
                    end
                    S_DEBP: begin
                        if (!s2[i]) begin
                            cnt <= '0;
                            st  <= S_IDLE;
                        end else begin
                            cnt <= cnt + ONE;
                            if (cnt == JIT_M1) begin
                                st   <= S_PRES;
                                down <= 1'b1;
                                pr   <= 1'b1;
                            end
                        end
                    end
                    S_PRES: begin
                        if (!s2[i]) begin
                            cnt  <= '0;
                            held <= 1'b0;
                            st   <= S_DEBR;
                        end else if (cnt == LONG_M1) begin
                            cnt <= LONG_MAX;
                            lg  <= 1'b1;
                            st  <= S_HELD;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_HELD: begin
                        if (!s2[i]) begin
                            cnt  <= '0;
                            held <= 1'b1;
                            st   <= S_DEBR;
                        end
                    end
                    S_DEBR: begin
                        // A bounce back resumes the press; long count restarts.
                        if (s2[i]) begin
                            cnt <= '0;
                            st  <= held ? S_HELD : S_PRES;
                        end else if (cnt == JIT_M1) begin
                            cnt  <= '0;
                            down <= 1'b0;
                            rl   <= 1'b1;
                            st   <= S_IDLE;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: begin
                        cnt <= '0;
                        st  <= S_IDLE;
                    end
                endcase
            end
        end

        assign down_v[i] = down;
        assign pr_v[i]   = pr;
        assign rl_v[i]   = rl;
        assign lg_v[i]   = lg;
    end

    always_ff @(posedge clk_12m or negedge srst_n) begin
        if (!srst_n) begin
            bus.key_state   <= '0;
            bus.key_press   <= '0;
            bus.key_release <= '0;
            bus.key_long    <= '0;
            bus.any_event   <= 1'b0;
        end else begin
            bus.key_state   <= down_v;
            bus.key_press   <= pr_v;
            bus.key_release <= rl_v;
            bus.key_long    <= lg_v;
            bus.any_event   <= |{bus.key_press, bus.key_release, bus.key_long};
        end
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: active-high and active-low instances.
module tb_key_debounce_multi;
    logic clk_12m = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_12m = ~clk_12m;

    key_debounce_multi_if #(.N_KEYS(4)) ifa ();
    key_debounce_multi_if #(.N_KEYS(4)) ifb ();

    key_debounce_multi #(
        .N_KEYS(4), .JITTER_CYC(20), .LONG_CYC(100), .ACTIVE_HIGH(1)
    ) u_a (
        .clk_12m(clk_12m),
        .rst_n  (rst_n),
        .bus    (ifa.slave)
    );

    key_debounce_multi #(
        .N_KEYS(4), .JITTER_CYC(20), .LONG_CYC(100), .ACTIVE_HIGH(0)
    ) u_b (
        .clk_12m(clk_12m),
        .rst_n  (rst_n),
        .bus    (ifb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int np[4], nr[4], nl[4], nsu[4];
    int tp[4], tr[4], tl[4], tsu[4], tsd[4];
    int nae, tae, clash;
    int bnp, bnr, btp, btr;
    logic [3:0] st_prev = '0;

    int t0, trel, rst_bad;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 4; c++) begin
            np[c] = 0; nr[c] = 0; nl[c] = 0; nsu[c] = 0;
            tp[c] = -1; tr[c] = -1; tl[c] = -1; tsu[c] = -1; tsd[c] = -1;
        end
        nae = 0; tae = -1;
        bnp = 0; bnr = 0; btp = -1; btr = -1;
    endtask

    task automatic tick();
        @(posedge clk_12m);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (ifa.key_press[c])   begin np[c]++; tp[c] = cyc; end
            if (ifa.key_release[c]) begin nr[c]++; tr[c] = cyc; end
            if (ifa.key_long[c])    begin nl[c]++; tl[c] = cyc; end
            if (ifa.key_press[c] && ifa.key_release[c]) clash++;
            if (ifa.key_press[c] && ifa.key_long[c])    clash++;
            if (ifa.key_state[c] && !st_prev[c]) begin nsu[c]++; tsu[c] = cyc; end
            if (!ifa.key_state[c] && st_prev[c]) tsd[c] = cyc;
            st_prev[c] = ifa.key_state[c];
        end
        if (ifa.any_event) begin
            nae++;
            if (tae < 0) tae = cyc;
        end
        if (ifb.key_press[0])   begin bnp++; btp = cyc; end
        if (ifb.key_release[0]) begin bnr++; btr = cyc; end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic outs_zero();
        return ifa.key_state == 0 && ifa.key_press == 0 &&
               ifa.key_release == 0 && ifa.key_long == 0 &&
               ifa.any_event == 1'b0;
    endfunction

    initial begin
        clash = 0;
        ifa.key_in = 4'h0;
        ifb.key_in = 4'hF;
        clear_stats();

        // Reset state
        ticks(4);
        chk("rst_outs_zero", outs_zero(), 1);
        chk("rst_b_state", ifb.key_state, 0);
        rst_n = 1'b1;
        ticks(10);
        chk("post_rst_idle", outs_zero(), 1);

        // Short press on key 0: press and release 23 cycles after sampling
        clear_stats();
        ifa.key_in[0] = 1'b1;
        t0 = cyc + 1;
        ticks(50);
        ifa.key_in[0] = 1'b0;
        trel = cyc + 1;
        ticks(40);
        chk("k0_press_n", np[0], 1);
        chk("k0_press_at", tp[0] - t0, 23);
        chk("k0_state_up", tsu[0] - t0, 23);
        chk("k0_rel_n", nr[0], 1);
        chk("k0_rel_at", tr[0] - trel, 23);
        chk("k0_state_dn", tsd[0] - trel, 23);
        chk("k0_long_n", nl[0], 0);

        // Bounce on key 1 every 5 cycles: nothing may come out
        clear_stats();
        for (int k = 0; k < 40; k++) begin
            ifa.key_in[1] = ~ifa.key_in[1];
            ticks(5);
        end
        ifa.key_in[1] = 1'b0;
        ticks(30);
        chk("k1_press_n", np[1], 0);
        chk("k1_rel_n", nr[1], 0);
        chk("k1_long_n", nl[1], 0);
        chk("k1_state_n", nsu[1], 0);
        chk("k1_any_event", nae, 0);

        // Long hold on key 2
        clear_stats();
        ifa.key_in[2] = 1'b1;
        t0 = cyc + 1;
        ticks(150);
        ifa.key_in[2] = 1'b0;
        trel = cyc + 1;
        ticks(40);
        chk("k2_press_at", tp[2] - t0, 23);
        chk("k2_long_n", nl[2], 1);
        chk("k2_long_at", tl[2] - t0, 103);
        chk("k2_rel_n", nr[2], 1);
        chk("k2_rel_at", tr[2] - trel, 23);

        // Simultaneous press on keys 0 and 3
        clear_stats();
        ifa.key_in = 4'b1001;
        t0 = cyc + 1;
        ticks(30);
        chk("k03_press0_at", tp[0] - t0, 23);
        chk("k03_same_cycle", tp[3] - tp[0], 0);
        chk("k03_any_event_at", tae - tp[0], 1);
        ifa.key_in = 4'h0;
        ticks(30);

        // Reset at cycle 30 of a held press, key still held on release
        clear_stats();
        ifa.key_in[0] = 1'b1;
        t0 = cyc + 1;
        ticks(30);
        chk("pre_rst_state", ifa.key_state[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", outs_zero(), 1);
        clear_stats();
        rst_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!outs_zero()) rst_bad++;
        end
        chk("rst_hold_zero", rst_bad, 0);
        rst_n = 1'b1;
        // rst_n sampled at the next edge; internal release follows one edge
        // later, so key_in is first sampled two edges on, then +23.
        trel = cyc + 1;
        ticks(40);
        chk("rst_no_release", nr[0], 0);
        chk("rst_press_n", np[0], 1);
        chk("rst_press_at", tp[0] - trel, 25);
        ifa.key_in[0] = 1'b0;
        ticks(30);

        // Active-low instance
        clear_stats();
        ifb.key_in[0] = 1'b0;
        t0 = cyc + 1;
        ticks(30);
        ifb.key_in[0] = 1'b1;
        trel = cyc + 1;
        ticks(40);
        chk("b_press_n", bnp, 1);
        chk("b_press_at", btp - t0, 23);
        chk("b_rel_n", bnr, 1);
        chk("b_rel_at", btr - trel, 23);

        chk("no_event_clash", clash, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, the number of independent key channels (1..16).
REQ-002 The block SHALL have parameter JITTER_CYC, default 180000, the stable-level debounce window in clk_12m cycles (15 ms at 12 MHz), legal range 2..2^20-1.
REQ-003 The block SHALL have parameter LONG_CYC, default 12000000, the hold time in cycles for a long-press event (1 s), legal range JITTER_CYC+1..2^24-1.
REQ-004 The block SHALL have parameter ACTIVE_HIGH, default 1; 1 = pressed when key_in is 1, 0 = pressed when key_in is 0.
REQ-005 Port clk_12m, input, 1 bit: 12 MHz system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port key_in, input, N_KEYS bits: raw asynchronous key pins, bit i = channel i.
REQ-008 Port key_state, output, N_KEYS bits: debounced level, 1 = pressed, independent of ACTIVE_HIGH.
REQ-009 Port key_press, output, N_KEYS bits: one-cycle pulse on each debounced press.
REQ-010 Port key_release, output, N_KEYS bits: one-cycle pulse on each debounced release.
REQ-011 Port key_long, output, N_KEYS bits: one-cycle pulse when a press has been held for LONG_CYC.
REQ-012 Port any_event, output, 1 bit: registered OR of key_press, key_release and key_long across all channels, delayed by one cycle.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer, after polarity normalisation, before any other logic.
REQ-014 Each channel SHALL run its own FSM with states IDLE, DEB_PRESS, PRESSED, HELD and DEB_RELEASE, and its own counter of width clog2(LONG_CYC+1).
REQ-015 IDLE: on a synchronized pressed level, the FSM SHALL clear the counter and go to DEB_PRESS.
REQ-016 DEB_PRESS: the counter SHALL increment each cycle the level is pressed.
REQ-017 DEB_PRESS: a released level SHALL return the FSM to IDLE with no event and the counter cleared.
REQ-018 DEB_PRESS: at counter = JITTER_CYC-1 with the level still pressed, the FSM SHALL go to PRESSED, set key_state, pulse key_press, and continue counting.
REQ-019 PRESSED: the counter SHALL keep incrementing.
REQ-020 PRESSED: at counter = LONG_CYC-1, the FSM SHALL pulse key_long and go to HELD, and the counter SHALL saturate with no wrap-around.
REQ-021 PRESSED or HELD: a released level SHALL clear the counter and move the FSM to DEB_RELEASE.
REQ-022 DEB_RELEASE: a pressed level SHALL return the FSM to its prior state (PRESSED or HELD) with the counter cleared and no event; the long-press count restarts from zero after the bounce.
REQ-023 DEB_RELEASE: at counter = JITTER_CYC-1 with the level still released, the FSM SHALL clear key_state, pulse key_release and go to IDLE.
REQ-024 Latency: key_press and key_release SHALL assert exactly JITTER_CYC+3 rising edges after the first edge that samples the new stable key_in level (2 synchronizer stages, the window, and 1 output register).
REQ-025 Event pulses SHALL be registered outputs, high for exactly one cycle per event, and never asserted in the same cycle on the same channel.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-027 A bounce shorter than JITTER_CYC cycles SHALL produce no event and no key_state change.

Reset
REQ-028 rst_n SHALL be asserted asynchronously and released synchronously through an internal 2-flop reset synchronizer.
REQ-029 All internal logic SHALL use the synchronized reset.
REQ-030 During reset, key_state, key_press, key_release, key_long and any_event SHALL be 0, all FSMs SHALL be in IDLE, and counters and synchronizers SHALL be 0 (released level).
REQ-031 Reset asserted mid-press SHALL abort the press with no release pulse.
REQ-032 A key held through reset release SHALL be treated as a new press and SHALL report key_press after the full debounce window.

Verification (N_KEYS=4, JITTER_CYC=20, LONG_CYC=100, ACTIVE_HIGH=1)
REQ-033 The bench SHALL apply key_in[0] 0->1 held 50 cycles then 1->0, and check: key_press[0] pulse at cycle 23, key_state[0]=1 from cycle 23, key_release[0] pulse 23 cycles after release, no key_long.
REQ-034 The bench SHALL toggle key_in[1] every 5 cycles for 200 cycles, and check: all outputs stay 0.
REQ-035 The bench SHALL hold key_in[2]=1 for 150 cycles, and check: key_press[2] at cycle 23, a single key_long[2] pulse at cycle 103, a single key_release[2] after release.
REQ-036 The bench SHALL press key_in[0] and key_in[3] on the same edge, and check: both key_press bits assert in the same cycle and any_event=1 exactly one cycle later.
REQ-037 The bench SHALL assert rst_n=0 at cycle 30 of a held press, then release it with the key still held, and check: outputs 0 during reset, no key_release, and a fresh key_press JITTER_CYC+3 cycles after the synchronized reset release.
REQ-038 The bench SHALL use ACTIVE_HIGH=0, key_in idle 1, and a low pulse of 30 cycles, and check: key_press at cycle 23 and key_release 23 cycles after key_in returns to 1.
